// File: rtl/ringtone_player_if.sv
// ringtone_player_if: control/status bundle between the phone UI and the
// ringtone player.
//   start/stop : one-cycle requests from the UI
//   audio_out  : square-wave speaker drive
//   busy/done  : playback status, done is a one-cycle completion pulse
//   note_idx   : current melody step for the display
interface ringtone_player_if;
  logic       start;
  logic       stop;
  logic       audio_out;
  logic       busy;
  logic       done;
  logic [2:0] note_idx;

  modport master (output start, stop, input audio_out, busy, done, note_idx);
  modport slave  (input start, stop, output audio_out, busy, done, note_idx);
endinterface

// File: rtl/ringtone_player.sv
// ringtone_player: sequences an eight-step melody, synthesising each note as a
// square wave from a half-period ROM, with a silent gap after every step.
//   basys_clock : system clock
//   reset       : synchronous, active-high
//   bus         : ringtone_player_if.slave (start/stop in, audio/status out)
// Parameters: NOTE_CYCLES / GAP_CYCLES set step timing, TONE_SHIFT scales the
// ROM half-periods down, LOOP selects repeat (1) or single play with done (0).
module ringtone_player #(
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned TONE_SHIFT  = 0,
  parameter int unsigned LOOP        = 1
) (
  input  logic               basys_clock,
  input  logic               reset,
  ringtone_player_if.slave   bus
);

  localparam logic [24:0] NOTE_LAST = 25'(NOTE_CYCLES - 1);
  localparam logic [24:0] GAP_LAST  = 25'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t      state;
  logic [16:0] tone_cnt;
  logic [24:0] dur_cnt;
  logic        audio_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  idx_q;
  logic [16:0] hp;

  // Half-periods in cycles: C5 E5 G5 C6 G5 E5 C5 rest.
  function automatic logic [16:0] rom_hp(input logic [2:0] i);
    case (i)
      3'd0:    return 17'd95556;
      3'd1:    return 17'd75843;
      3'd2:    return 17'd63775;
      3'd3:    return 17'd47778;
      3'd4:    return 17'd63775;
      3'd5:    return 17'd75843;
      3'd6:    return 17'd95556;
      default: return 17'd0;
    endcase
  endfunction

  assign hp = rom_hp(idx_q) >> TONE_SHIFT;

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state    <= IDLE;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      audio_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // stop wins over a simultaneous start
          if (bus.start && !bus.stop) begin
            state    <= TONE;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
            audio_q  <= 1'b0;
          end
        end
        TONE: begin
          if (bus.stop) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
            audio_q  <= 1'b0;
          end else if (dur_cnt == NOTE_LAST) begin
            // last half-period is truncated here; speaker goes quiet for the gap
            state    <= GAP;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            audio_q  <= 1'b0;
          end else begin
            dur_cnt <= dur_cnt + 25'd1;
            if (hp == 17'd0) begin
              tone_cnt <= '0;
              audio_q  <= 1'b0;
            end else if (tone_cnt == hp - 17'd1) begin
              tone_cnt <= '0;
              audio_q  <= ~audio_q;
            end else begin
              tone_cnt <= tone_cnt + 17'd1;
            end
          end
        end
        GAP: begin
          if (bus.stop) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
            audio_q  <= 1'b0;
          end else if (dur_cnt == GAP_LAST) begin
            dur_cnt  <= '0;
            tone_cnt <= '0;
            audio_q  <= 1'b0;
            if (idx_q != 3'd7) begin
              idx_q <= idx_q + 3'd1;
              state <= TONE;
            end else if (LOOP != 0) begin
              idx_q <= '0;
              state <= TONE;
            end else begin
              idx_q  <= '0;
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            dur_cnt <= dur_cnt + 25'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.audio_out = audio_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.note_idx  = idx_q;

endmodule

// File: tb/tb_ringtone_player.sv
// Bench for ringtone_player: a LOOP=0 and a LOOP=1 instance share stimulus.
// Every change of an output vector {audio, busy, done, note_idx} is popped
// from a per-instance expected-event queue and compared for time and value.
module tb_ringtone_player;

  typedef struct {
    int         t;
    logic [5:0] v;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic stop;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;
  bit mon_en   = 1'b0;

  ev_t        q0[$];
  ev_t        q1[$];
  logic [5:0] prev [2];
  logic [5:0] vec  [2];

  // expected output fields, common to both instances
  logic       e_aud, e_busy, e_done;
  logic [2:0] e_idx;

  int hp_exp [8] = '{93, 74, 62, 46, 62, 74, 93, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ringtone_player_if if0 ();
  ringtone_player_if if1 ();

  assign if0.start = start;
  assign if0.stop  = stop;
  assign if1.start = start;
  assign if1.stop  = stop;

  ringtone_player #(.NOTE_CYCLES(1000), .GAP_CYCLES(100), .TONE_SHIFT(10), .LOOP(0))
    dut0 (.basys_clock(clk), .reset(reset), .bus(if0));
  ringtone_player #(.NOTE_CYCLES(1000), .GAP_CYCLES(100), .TONE_SHIFT(10), .LOOP(1))
    dut1 (.basys_clock(clk), .reset(reset), .bus(if1));

  assign vec[0] = {if0.audio_out, if0.busy, if0.done, if0.note_idx};
  assign vec[1] = {if1.audio_out, if1.busy, if1.done, if1.note_idx};

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic push_one(input int d, input int t, input logic [5:0] v);
    ev_t e;
    e.t = t;
    e.v = v;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_both(input int t);
    push_one(0, t, {e_aud, e_busy, e_done, e_idx});
    push_one(1, t, {e_aud, e_busy, e_done, e_idx});
  endtask

  // Expected events of one melody step starting at off+1100*i, cut at t_stop.
  task automatic gen_step(input int i, input int off, input int t_stop);
    int t0;
    int h;
    t0 = off + 1100 * i;
    h  = hp_exp[i];
    if (t0 >= t_stop) return;
    if (i != 0) begin
      e_idx = 3'(i);
      push_both(t0);
    end
    if (h != 0)
      for (int j = 1; h * j <= 999; j++)
        if (t0 + h * j < t_stop) begin
          e_aud = ~e_aud;
          push_both(t0 + h * j);
        end
    if (e_aud && (t0 + 1000 < t_stop)) begin
      e_aud = 1'b0;
      push_both(t0 + 1000);
    end
  endtask

  task automatic sb_check(input int d);
    ev_t        e;
    logic [5:0] v;
    int         rel;
    bit         empty;
    v   = vec[d];
    rel = cyc - base;
    if (v === prev[d]) return;
    prev[d] = v;
    checks++;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      failures++;
      $display("FAIL sb%0d unexpected change t=%0d got=%b", d, rel, v);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.t != rel || e.v !== v) begin
      failures++;
      $display("FAIL sb%0d event got=%b@%0d exp=%b@%0d", d, v, rel, e.v, e.t);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      sb_check(0);
      sb_check(1);
    end
  end

  // Called at a negedge: returns at the negedge just before relative edge t.
  task automatic wait_rel(input int t);
    while (cyc + 1 < base + t) @(negedge clk);
  endtask

  task automatic q_empty(input string name);
    chk({name, "_q0_left"}, 6'(q0.size()), 6'd0);
    chk({name, "_q1_left"}, 6'(q1.size()), 6'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    prev[0] = 6'd0;
    prev[1] = 6'd0;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    e_aud = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = 3'd0;

    // reset held 5 cycles, with a start pulse that must be ignored
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state0", vec[0], 6'd0);
    chk("reset_state1", vec[1], 6'd0);
    mon_en = 1'b1;

    // start and stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (20) @(negedge clk);
    chk("start_stop_idle0", vec[0], 6'd0);
    chk("start_stop_idle1", vec[1], 6'd0);

    // full melody; LOOP=0 completes, LOOP=1 wraps and is then stopped
    base = cyc + 1;
    e_busy = 1'b1;
    push_both(0);
    for (int i = 0; i < 8; i++) gen_step(i, 0, 1 << 30);
    push_one(0, 8800, 6'b001_000);
    push_one(0, 8801, 6'b000_000);
    push_one(1, 8800, 6'b010_000);
    push_one(1, 8893, 6'b110_000);
    push_one(1, 8986, 6'b010_000);
    push_one(1, 9079, 6'b110_000);
    push_one(1, 9100, 6'b000_000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(500);            // re-start while busy: no effect
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(9100);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_rel(9200);
    q_empty("run1");

    // stop mid step 2, restart, then reset mid-note
    e_aud = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_idx = 3'd0;
    base = cyc + 1;
    push_both(0);
    for (int i = 0; i < 3; i++) gen_step(i, 0, 2500);
    e_aud = 1'b0; e_busy = 1'b0; e_idx = 3'd0;
    push_both(2500);
    e_busy = 1'b1;
    push_both(2600);
    gen_step(0, 2600, 3000);
    e_aud = 1'b0; e_busy = 1'b0; e_idx = 3'd0;
    push_both(3000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(2500);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_rel(2600);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(3000);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("after_reset0", vec[0], 6'd0);
    chk("after_reset1", vec[1], 6'd0);
    wait_rel(3100);
    q_empty("run2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
